// File: rtl/ps2_pkg.sv
// Shared constants, decoder state encoding and event layout for the PS/2 key event path.
package ps2_pkg;

  localparam logic [7:0] SC_EXT   = 8'hE0;
  localparam logic [7:0] SC_BRK   = 8'hF0;
  localparam logic [7:0] SC_PAUSE = 8'hE1;

  localparam logic [7:0] SC_FAKE_SHIFT_L = 8'h12;
  localparam logic [7:0] SC_FAKE_SHIFT_R = 8'h59;

  // Bytes that follow the E1 prefix before the single pause event is emitted.
  localparam logic [2:0] PAUSE_SKIP = 3'd6;

  localparam int EVT_CODE_LSB = 0;
  localparam int EVT_BRK_BIT  = 8;
  localparam int EVT_EXT_BIT  = 9;
  localparam int EVT_SYS_BIT  = 10;
  localparam int EVT_W        = 11;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_GOT_E0,
    ST_GOT_F0,
    ST_GOT_E0F0,
    ST_PAUSE
  } dec_state_t;

  function automatic logic is_sys_byte(input logic [7:0] b);
    case (b)
      8'hAA, 8'hEE, 8'hFA, 8'hFC, 8'hFD, 8'hFE, 8'h00, 8'hFF: is_sys_byte = 1'b1;
      default:                                                is_sys_byte = 1'b0;
    endcase
  endfunction

  function automatic logic [EVT_W-1:0] make_evt(input logic sys, input logic ext,
                                                input logic brk, input logic [7:0] code);
    logic [EVT_W-1:0] e;
    e = '0;
    e[EVT_SYS_BIT] = sys;
    e[EVT_EXT_BIT] = ext;
    e[EVT_BRK_BIT] = brk;
    e[EVT_CODE_LSB +: 8] = code;
    return e;
  endfunction

endpackage

// File: rtl/ps2_evt_fifo.sv
// Show-ahead synchronous FIFO: head entry is visible on head_data whenever not empty.
module ps2_evt_fifo #(
  parameter int WIDTH = 11,
  parameter int DEPTH = 16
) (
  input  logic                     clk,
  input  logic                     nRESET,
  input  logic                     push,
  input  logic [WIDTH-1:0]         push_data,
  input  logic                     pop,
  output logic [WIDTH-1:0]         head_data,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [AW:0]      count_q, count_d;
  logic             do_push, do_pop;

  assign empty = (count_q == '0);
  assign full  = (count_q == (AW+1)'(DEPTH));
  assign count = count_q;

  // Pop on empty is ignored; a push into a full FIFO only lands if a pop frees a slot.
  assign do_pop  = pop && !empty;
  assign do_push = push && (!full || do_pop);

  always_comb begin
    wr_ptr_d = do_push ? wr_ptr_q + 1'b1 : wr_ptr_q;
    rd_ptr_d = do_pop  ? rd_ptr_q + 1'b1 : rd_ptr_q;
    count_d  = count_q;
    case ({do_push, do_pop})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk or negedge nRESET) begin
    if (!nRESET) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr_q] <= push_data;
  end

  assign head_data = empty ? '0 : mem[rd_ptr_q];

endmodule

// File: rtl/ps2_key_event_fifo.sv
// Decodes Scan Code Set 2 prefix sequences into key events and buffers them for the CPU.
module ps2_key_event_fifo
  import ps2_pkg::*;
#(
  parameter int DEPTH             = 16,
  parameter int TIMEOUT_CYCLES    = 2000000,
  parameter bit FILTER_FAKE_SHIFT = 1'b1
) (
  input  logic                   clk,
  input  logic                   nRESET,
  input  logic [7:0]             in_data,
  input  logic                   in_valid,
  input  logic                   in_error,
  input  logic                   pop,
  output logic [EVT_W-1:0]       evt_data,
  output logic                   evt_valid,
  output logic [$clog2(DEPTH):0] count,
  output logic                   overflow,
  output logic                   rx_err,
  input  logic                   clr_flags
);

  localparam int TW = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES + 1) : 1;
  localparam logic [TW-1:0] TMO_LAST = (TIMEOUT_CYCLES == 0) ? '0 : TW'(TIMEOUT_CYCLES - 1);

  dec_state_t       state_q, state_d;
  logic [2:0]       skip_q, skip_d;
  logic             push_q, push_d;
  logic [EVT_W-1:0] evt_q, evt_d;
  logic [TW-1:0]    tmo_q, tmo_d;
  logic             overflow_q, overflow_d;
  logic             rx_err_q, rx_err_d;
  logic             byte_ok, tmo_hit, is_fake, fifo_full, fifo_empty;

  assign byte_ok = in_valid && !in_error;
  assign is_fake = FILTER_FAKE_SHIFT &&
                   (in_data == SC_FAKE_SHIFT_L || in_data == SC_FAKE_SHIFT_R);
  // Fires on the edge where the idle counter would reach TIMEOUT_CYCLES.
  assign tmo_hit = (TIMEOUT_CYCLES != 0) && (state_q != ST_IDLE) && !in_valid && !in_error &&
                   (tmo_q == TMO_LAST);

  always_ff @(posedge clk or negedge nRESET) begin
    if (!nRESET) begin
      state_q    <= ST_IDLE;
      skip_q     <= '0;
      push_q     <= 1'b0;
      evt_q      <= '0;
      tmo_q      <= '0;
      overflow_q <= 1'b0;
      rx_err_q   <= 1'b0;
    end else begin
      state_q    <= state_d;
      skip_q     <= skip_d;
      push_q     <= push_d;
      evt_q      <= evt_d;
      tmo_q      <= tmo_d;
      overflow_q <= overflow_d;
      rx_err_q   <= rx_err_d;
    end
  end

  always_comb begin
    state_d = state_q;
    if (in_error || tmo_hit) begin
      state_d = ST_IDLE;
    end else if (in_valid) begin
      case (state_q)
        ST_IDLE: begin
          if (in_data == SC_EXT)        state_d = ST_GOT_E0;
          else if (in_data == SC_BRK)   state_d = ST_GOT_F0;
          else if (in_data == SC_PAUSE) state_d = ST_PAUSE;
        end
        ST_GOT_E0: begin
          if (in_data == SC_BRK)        state_d = ST_GOT_E0F0;
          else if (in_data != SC_EXT)   state_d = ST_IDLE;
        end
        ST_PAUSE:  if (skip_q == '0)    state_d = ST_IDLE;
        default:                        state_d = ST_IDLE;
      endcase
    end
  end

  always_comb begin
    push_d = 1'b0;
    evt_d  = '0;
    skip_d = skip_q;
    if (byte_ok) begin
      case (state_q)
        ST_IDLE: begin
          if (in_data == SC_PAUSE) begin
            skip_d = PAUSE_SKIP;
          end else if (in_data != SC_EXT && in_data != SC_BRK) begin
            push_d = 1'b1;
            evt_d  = make_evt(is_sys_byte(in_data), 1'b0, 1'b0, in_data);
          end
        end
        ST_GOT_E0: begin
          if (in_data != SC_EXT && in_data != SC_BRK) begin
            push_d = !is_fake;
            evt_d  = make_evt(1'b0, 1'b1, 1'b0, in_data);
          end
        end
        ST_GOT_F0: begin
          push_d = 1'b1;
          evt_d  = make_evt(1'b0, 1'b0, 1'b1, in_data);
        end
        ST_GOT_E0F0: begin
          push_d = !is_fake;
          evt_d  = make_evt(1'b0, 1'b1, 1'b1, in_data);
        end
        ST_PAUSE: begin
          if (skip_q == '0) begin
            push_d = 1'b1;
            evt_d  = make_evt(1'b0, 1'b1, 1'b0, SC_PAUSE);
          end else begin
            skip_d = skip_q - 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  always_comb begin
    if (TIMEOUT_CYCLES == 0 || state_q == ST_IDLE || in_valid || in_error || tmo_hit)
      tmo_d = '0;
    else
      tmo_d = tmo_q + 1'b1;
  end

  // Set conditions win over clr_flags in the same cycle.
  always_comb begin
    overflow_d = overflow_q;
    rx_err_d   = rx_err_q;
    if (clr_flags) begin
      overflow_d = 1'b0;
      rx_err_d   = 1'b0;
    end
    if (push_q && fifo_full && !pop) overflow_d = 1'b1;
    if (in_error || tmo_hit)         rx_err_d   = 1'b1;
  end

  ps2_evt_fifo #(
    .WIDTH (EVT_W),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk       (clk),
    .nRESET    (nRESET),
    .push      (push_q),
    .push_data (evt_q),
    .pop       (pop),
    .head_data (evt_data),
    .full      (fifo_full),
    .empty     (fifo_empty),
    .count     (count)
  );

  assign evt_valid = !fifo_empty;
  assign overflow  = overflow_q;
  assign rx_err    = rx_err_q;

endmodule

// File: tb/tb_ps2_key_event_fifo.sv
// Scoreboard bench for ps2_key_event_fifo with a small FIFO and short prefix timeout.
module tb_ps2_key_event_fifo;

  localparam int DEPTH = 4;
  localparam int TMO   = 100;

  logic        clk = 1'b0;
  logic        nRESET = 1'b0;
  logic [7:0]  in_data = '0;
  logic        in_valid = 1'b0;
  logic        in_error = 1'b0;
  logic        pop = 1'b0;
  logic        clr_flags = 1'b0;
  logic [10:0] evt_data;
  logic        evt_valid;
  logic [2:0]  count;
  logic        overflow;
  logic        rx_err;

  int checks = 0;
  int errors = 0;
  logic [10:0] exp_q [$];

  always #5 clk = ~clk;

  ps2_key_event_fifo #(
    .DEPTH             (DEPTH),
    .TIMEOUT_CYCLES    (TMO),
    .FILTER_FAKE_SHIFT (1'b1)
  ) dut (
    .clk       (clk),
    .nRESET    (nRESET),
    .in_data   (in_data),
    .in_valid  (in_valid),
    .in_error  (in_error),
    .pop       (pop),
    .evt_data  (evt_data),
    .evt_valid (evt_valid),
    .count     (count),
    .overflow  (overflow),
    .rx_err    (rx_err),
    .clr_flags (clr_flags)
  );

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) @(negedge clk);
  endtask

  task automatic send_byte(input logic [7:0] b);
    @(negedge clk);
    in_data  = b;
    in_valid = 1'b1;
    @(negedge clk);
    in_valid = 1'b0;
    $display("byte 0x%02h sent", b);
  endtask

  task automatic send_error();
    @(negedge clk);
    in_error = 1'b1;
    @(negedge clk);
    in_error = 1'b0;
    $display("in_error pulse sent");
  endtask

  task automatic do_clr();
    @(negedge clk);
    clr_flags = 1'b1;
    @(negedge clk);
    clr_flags = 1'b0;
  endtask

  task automatic check_count(input string name, input int exp);
    checks++;
    if (count !== 3'(exp)) begin
      errors++;
      $display("FAIL %s: count=%0d expected %0d", name, count, exp);
    end else $display("%s: count=%0d ok", name, count);
  endtask

  // Pops every scoreboard entry, comparing the head before each pop.
  task automatic drain(input string name);
    logic [10:0] e;
    int guard = 0;
    while (exp_q.size() > 0 && guard < 32) begin
      guard++;
      e = exp_q.pop_front();
      checks++;
      if (evt_valid !== 1'b1 || evt_data !== e) begin
        errors++;
        $display("FAIL %s: evt_valid=%b evt_data=0x%03h expected 0x%03h", name, evt_valid, evt_data, e);
      end else $display("%s: event 0x%03h ok", name, evt_data);
      @(negedge clk);
      pop = 1'b1;
      @(negedge clk);
      pop = 1'b0;
    end
    checks++;
    if (evt_valid !== 1'b0) begin
      errors++;
      $display("FAIL %s_empty: evt_valid=%b expected 0 (extra event 0x%03h)", name, evt_valid, evt_data);
    end
  endtask

  task automatic test_reset();
    nRESET = 1'b0;
    idle(2);
    checks++;
    if ({evt_valid, count, overflow, rx_err, evt_data} !== 17'd0) begin
      errors++;
      $display("FAIL reset: valid=%b count=%0d ovf=%b rx_err=%b data=0x%03h expected all 0",
               evt_valid, count, overflow, rx_err, evt_data);
    end else $display("reset: outputs idle ok");
    @(negedge clk);
    nRESET = 1'b1;
    idle(1);
  endtask

  task automatic test_make_break();
    send_byte(8'h1C); exp_q.push_back(11'h01C);
    send_byte(8'hF0);
    send_byte(8'h1C); exp_q.push_back(11'h11C);
    idle(2);
    check_count("make_break", 2);
    drain("make_break");
  endtask

  task automatic test_extended();
    send_byte(8'hE0); send_byte(8'h75); exp_q.push_back(11'h275);
    send_byte(8'hE0); send_byte(8'hF0); send_byte(8'h75); exp_q.push_back(11'h375);
    send_byte(8'hE0); send_byte(8'h12);
    send_byte(8'hE0); send_byte(8'hF0); send_byte(8'h59);
    send_byte(8'hE0); send_byte(8'hE0); send_byte(8'h6B); exp_q.push_back(11'h26B);
    idle(2);
    check_count("extended", 3);
    drain("extended");
  endtask

  task automatic test_pause();
    logic [7:0] seq [8] = '{8'hE1, 8'h14, 8'h77, 8'hE1, 8'hF0, 8'h14, 8'hF0, 8'h77};
    for (int i = 0; i < 8; i++) send_byte(seq[i]);
    exp_q.push_back(11'h2E1);
    send_byte(8'h1C); exp_q.push_back(11'h01C);
    idle(2);
    check_count("pause", 2);
    drain("pause");
  endtask

  task automatic test_system_and_error();
    send_byte(8'hAA); exp_q.push_back(11'h4AA);
    send_byte(8'hF0);
    send_error();
    send_byte(8'h1C); exp_q.push_back(11'h01C);
    idle(2);
    checks++;
    if (rx_err !== 1'b1) begin
      errors++;
      $display("FAIL rx_err_set: rx_err=%b expected 1", rx_err);
    end
    drain("system_error");
    do_clr();
    checks++;
    if (rx_err !== 1'b0) begin
      errors++;
      $display("FAIL rx_err_clr: rx_err=%b expected 0", rx_err);
    end else $display("rx_err cleared ok");
  endtask

  task automatic test_overflow();
    logic [7:0] codes [5] = '{8'h15, 8'h1D, 8'h24, 8'h2D, 8'h2C};
    logic [10:0] e;
    for (int i = 0; i < 5; i++) begin
      send_byte(codes[i]);
      if (i < DEPTH) exp_q.push_back({3'b000, codes[i]});
    end
    idle(2);
    check_count("overflow_full", 4);
    checks++;
    if (overflow !== 1'b1 || evt_data !== 11'h015) begin
      errors++;
      $display("FAIL overflow_set: ovf=%b head=0x%03h expected 1 and 0x015", overflow, evt_data);
    end else $display("overflow set, head 0x015 ok");
    do_clr();
    // Pop on the same edge the next event is written while full.
    @(negedge clk);
    in_data = 8'h35; in_valid = 1'b1;
    @(negedge clk);
    in_valid = 1'b0;
    e = exp_q.pop_front();
    checks++;
    if (evt_data !== e) begin
      errors++;
      $display("FAIL full_pop_head: evt_data=0x%03h expected 0x%03h", evt_data, e);
    end
    pop = 1'b1;
    exp_q.push_back(11'h035);
    @(negedge clk);
    pop = 1'b0;
    idle(1);
    check_count("full_push_pop", 4);
    checks++;
    if (overflow !== 1'b0) begin
      errors++;
      $display("FAIL full_push_pop_ovf: ovf=%b expected 0", overflow);
    end
    drain("overflow");
  endtask

  task automatic test_timeout();
    do_clr();
    send_byte(8'hE0);
    idle(TMO);
    send_byte(8'h1C); exp_q.push_back(11'h01C);
    idle(2);
    checks++;
    if (rx_err !== 1'b1) begin
      errors++;
      $display("FAIL timeout_rx_err: rx_err=%b expected 1", rx_err);
    end
    drain("timeout");
    // Short gaps must not time out.
    do_clr();
    send_byte(8'hE0);
    idle(TMO - 10);
    send_byte(8'h74); exp_q.push_back(11'h274);
    idle(2);
    checks++;
    if (rx_err !== 1'b0) begin
      errors++;
      $display("FAIL no_timeout_rx_err: rx_err=%b expected 0", rx_err);
    end
    drain("no_timeout");
  endtask

  task automatic test_reset_mid();
    send_byte(8'h1C);
    send_byte(8'h32);
    idle(2);
    check_count("pre_reset", 2);
    send_byte(8'hF0);
    @(negedge clk);
    nRESET = 1'b0;
    #1;
    check_count("async_reset", 0);
    exp_q.delete();
    @(negedge clk);
    nRESET = 1'b1;
    send_byte(8'h1C); exp_q.push_back(11'h01C);
    idle(2);
    drain("after_reset");
  endtask

  initial begin
    test_reset();
    test_make_break();
    test_extended();
    test_pause();
    test_system_and_error();
    test_overflow();
    test_timeout();
    test_reset_mid();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
